pic_host_bus_master: RTL and testbench
======================================

// Module: pic_host_bus_master
// PURPOSE
//  Host-side initiator for the PIC CPU interface: generates CSn/wrn/rdn/A0 cycles and drives/samples D.
//  Runs the ICW1..ICW4 init sequence on request, then OCW writes and status reads from a one-deep request port.
//  Sits between the test/CPU model and the PIC's read/write control logic and data bus buffer.
// PARAMETERS
//  TSU    1  cycles CSn/A0/D valid before strobe falls (>=1)
//  TPW    2  cycles strobe (wrn/rdn/inta_n) held low (>=1)
//  THD    1  cycles CSn/A0/D held after strobe rises (>=1)
//  TREC   2  cycles CSn high between bus cycles (>=1)
//  CNT_W  4  phase counter width; all T* must be < 2**CNT_W
// PORTS
//  clk        in   1  single clock, all logic rising-edge
//  rstn       in   1  asynchronous, active-low reset
//  init_go    in   1  one-cycle pulse: start ICW sequence using icw1..icw4
//  icw1..icw4 in   8  each: init words, sampled on init_go
//  init_done  out  1  high after last ICW written; cleared by init_go
//  err_icw1   out  1  sticky: init_go with icw1[4]==0; cleared by next init_go
//  req_valid  in   1  single-access request
//  req_ready  out  1  request accepted when valid&ready
//  req_rd     in   1  1=read cycle, 0=write cycle
//  req_a0     in   1  A0 value for the access
//  req_wdata  in   8  write data
//  rsp_valid  out  1  one-cycle pulse, read data valid
//  rsp_rdata  out  8  read data, held until next read
//  CSn, wrn, rdn  out 1 each  PIC bus strobes, active-low
//  A0         out  1  PIC register select
//  D          inout [0:7]  data bus, D[i] = data bit i; Z when not writing
// BEHAVIOUR
//  Reset: CSn=wrn=rdn=1, A0=0, D=Z, init_done=0, err_icw1=0, req_ready=0, rsp_valid=0, rsp_rdata=0.
//  Reset asserted mid-cycle: all strobes high and D released asynchronously; sequence aborted.
//  Bus FSM: IDLE -> SETUP(TSU) -> STROBE(TPW) -> HOLD(THD) -> RECOV(TREC) -> IDLE.
//   SETUP: CSn=0, A0 valid, D driven (writes only). STROBE: wrn or rdn low.
//   Read: D sampled on last STROBE cycle; rsp_rdata updated and rsp_valid=1 on first HOLD cycle.
//   Never wrn and rdn low together; D never driven while rdn=0.
//  Write cycle length = TSU+TPW+THD+TREC clocks; next cycle may start in cycle after RECOV.
//  Init sequence (seq pointer): ICW1 (A0=0) -> ICW2 (A0=1) -> ICW3 (A0=1) only if icw1[1]==0
//   -> ICW4 (A0=1) only if icw1[0]==1 -> init_done=1 on the cycle RECOV of last write ends.
//  icw1[4]==0 on init_go: no bus cycles, err_icw1=1, init_done stays 0.
//  req_ready = IDLE & init_done & no init pending. Accepted request runs one bus cycle.
//  init_go while busy: ignored unless FSM in IDLE; init_go in same cycle as req_valid: init wins, req not accepted.
//  Priority at IDLE: init sequence > INTA (if enabled) > single access.
// CONFIGURATION
//  PIC_INTA_EN defined: extra ports intr(in 1), inta_n(out 1, reset 1), vec_valid(out 1), vec(out 8).
//   intr high at IDLE with init_done -> two INTA cycles (CSn stays 1, inta_n low TPW, D=Z, TREC gap);
//   D sampled at end of 2nd pulse -> vec, vec_valid one-cycle pulse; intr re-sampled only after.
//  PIC_INTA_EN undefined: ports absent, no INTA states; intr never considered.
// STRUCTURE
//  Package pic_pkg: bus_state_t {IDLE,SETUP,STROBE,HOLD,RECOV}, seq_t {ICW1..ICW4,ACC,INTA1,INTA2},
//   ICW1 bit constants (IC4=0, SNGL=1, ICW1_ID=4), A0 constants for ICW/OCW selects.
//  Sub-module pic_bus_cycle: timing engine (FSM + CNT_W counter) taking start/rd/a0/wdata, giving done/rdata.
//  Top: sequence pointer, init/request/INTA arbitration, D tri-state driver.
// TESTING
//  1 init_go, icw1=8'h13 (SNGL,IC4), icw2=8'h20, icw4=8'h01 -> writes h13@A0=0, h20@A0=1, h01@A0=1; no ICW3; init_done.
//  2 icw1=8'h11 -> four writes incl. icw3@A0=1; each wrn low exactly TPW=2 clocks, CSn low 4 clocks, 2-clock gap.
//  3 icw1=8'h03 -> zero bus activity, err_icw1=1, init_done=0, req_ready=0.
//  4 after init: write A0=0 h0B (OCW3), then read A0=0 with model driving h5A -> rsp_valid once, rsp_rdata=h5A, D Z during rdn low.
//  5 rstn low during STROBE of ICW2 -> strobes high, D=Z same cycle; after release init_done=0, FSM IDLE.
//  6 (PIC_INTA_EN) intr=1, model drives h48 on 2nd inta_n -> two inta_n pulses, CSn=1, vec=h48, vec_valid one pulse.

Source files
------------

// File: rtl/pic_pkg.sv
// pic_pkg: shared bus/sequence types, ICW1 bit positions and A0 selects for the PIC host bus master
package pic_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOV} bus_state_t;
  typedef enum logic [2:0] {SEQ_IDLE, ICW1, ICW2, ICW3, ICW4, ACC, INTA1, INTA2} seq_t;
  localparam int IC4 = 0;
  localparam int SNGL = 1;
  localparam int ICW1_ID = 4;
  localparam logic A0_ICW1 = 1'b0;
  localparam logic A0_ICWN = 1'b1;
  // step that follows a finished bus cycle; SEQ_IDLE ends the chain
  function automatic seq_t next_seq(input seq_t s, input logic sngl, input logic ic4);
    case (s)
      ICW1: next_seq = ICW2;
      ICW2: next_seq = !sngl ? ICW3 : ic4 ? ICW4 : SEQ_IDLE;
      ICW3: next_seq = ic4 ? ICW4 : SEQ_IDLE;
      INTA1: next_seq = INTA2;
      default: next_seq = SEQ_IDLE;
    endcase
  endfunction
endpackage

// File: rtl/pic_bus_cycle.sv
// pic_bus_cycle: timing engine for one setup/strobe/hold/recovery bus cycle
module pic_bus_cycle import pic_pkg::*; #(
  parameter int TSU = 1,
  parameter int TPW = 2,
  parameter int THD = 1,
  parameter int TREC = 2,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       rd,
  input  logic       ia,
  input  logic       a0,
  input  logic [7:0] wdata,
  output logic       idle,
  output logic       done,
  output logic       smp,
  output logic       oe,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       ia_n,
  output logic       a0_q,
  output logic [7:0] wd
);
  bus_state_t state, nstate;
  logic [CNT_W-1:0] cnt, ncnt, lim;
  logic rd_q, ia_q, last, go, act;
  // phase length, next state/counter and strobe decode; a new cycle may start on the last RECOV clock
  always_comb begin
    lim = state == SETUP ? CNT_W'(TSU - 1) : state == STROBE ? CNT_W'(TPW - 1) :
          state == HOLD ? CNT_W'(THD - 1) : CNT_W'(TREC - 1);
    last = cnt == lim;
    idle = state == IDLE;
    done = state == RECOV && last;
    go = start && (idle || done);
    nstate = go ? SETUP : (idle || !last) ? state : state == SETUP ? STROBE :
             state == STROBE ? HOLD : state == HOLD ? RECOV : IDLE;
    ncnt = (idle || go || last) ? '0 : cnt + 1'b1;
    act = state == SETUP || state == STROBE || state == HOLD;
    smp = state == STROBE && last && (rd_q || ia_q);
    oe = act && !rd_q && !ia_q;
    cs_n = !act || ia_q;
    wr_n = !(state == STROBE && !rd_q && !ia_q);
    rd_n = !(state == STROBE && rd_q && !ia_q);
    ia_n = !(state == STROBE && ia_q);
  end
  // state and phase counter
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= nstate;
      cnt <= ncnt;
    end
  // cycle attributes captured when a cycle starts
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rd_q <= 1'b0;
      ia_q <= 1'b0;
      a0_q <= 1'b0;
      wd <= '0;
    end else if (go) begin
      rd_q <= rd;
      ia_q <= ia;
      a0_q <= a0;
      wd <= wdata;
    end
endmodule

// File: rtl/pic_host_bus_master.sv
// pic_host_bus_master: PIC CPU-interface initiator (ICW init, OCW writes, status reads); PIC_INTA_EN adds INTA cycles
module pic_host_bus_master import pic_pkg::*; #(
  parameter int TSU = 1,
  parameter int TPW = 2,
  parameter int THD = 1,
  parameter int TREC = 2,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       init_go,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  output logic       init_done,
  output logic       err_icw1,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rd,
  input  logic       req_a0,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       CSn,
  output logic       wrn,
  output logic       rdn,
  output logic       A0,
  inout  tri   [0:7] D
`ifdef PIC_INTA_EN
  ,
  input  logic       intr,
  output logic       inta_n,
  output logic       vec_valid,
  output logic [7:0] vec
`endif
);
  seq_t seq, nseq;
  logic c_sngl, c_ic4, idle, done, smp, oe, start, rd, ia, a0, irq, ia_n;
  logic [7:0] ic2, ic3, ic4, wdata, wd, din;
  pic_bus_cycle #(.TSU(TSU), .TPW(TPW), .THD(THD), .TREC(TREC), .CNT_W(CNT_W)) u_bus (
    .clk(clk), .rstn(rstn), .start(start), .rd(rd), .ia(ia), .a0(a0), .wdata(wdata),
    .idle(idle), .done(done), .smp(smp), .oe(oe), .cs_n(CSn), .wr_n(wrn), .rd_n(rdn),
    .ia_n(ia_n), .a0_q(A0), .wd(wd)
  );
  for (genvar i = 0; i < 8; i++) begin : g_d
    assign D[i] = oe ? wd[i] : 1'bz;
    assign din[i] = D[i];
  end
  // arbitration: init chain continues back-to-back; at IDLE init > INTA > single access
  always_comb begin
    nseq = done ? next_seq(seq, c_sngl, c_ic4) : !idle ? seq :
           init_go ? (icw1[ICW1_ID] ? ICW1 : SEQ_IDLE) :
           (init_done && irq) ? INTA1 : (init_done && req_valid) ? ACC : SEQ_IDLE;
    start = (idle || done) && nseq != SEQ_IDLE;
    req_ready = idle && init_done && !init_go && !irq;
    rd = nseq == ACC && req_rd;
    ia = nseq == INTA1 || nseq == INTA2;
    a0 = nseq == ICW1 ? A0_ICW1 : nseq == ACC ? req_a0 : A0_ICWN;
    wdata = nseq == ICW1 ? icw1 : nseq == ICW2 ? ic2 : nseq == ICW3 ? ic3 :
            nseq == ICW4 ? ic4 : req_wdata;
  end
  // sequence pointer, latched init words and init status flags
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      seq <= SEQ_IDLE;
      c_sngl <= 1'b0;
      c_ic4 <= 1'b0;
      ic2 <= '0;
      ic3 <= '0;
      ic4 <= '0;
      init_done <= 1'b0;
      err_icw1 <= 1'b0;
    end else begin
      seq <= nseq;
      if (idle && init_go) begin
        c_sngl <= icw1[SNGL];
        c_ic4 <= icw1[IC4];
        ic2 <= icw2;
        ic3 <= icw3;
        ic4 <= icw4;
        init_done <= 1'b0;
        err_icw1 <= !icw1[ICW1_ID];
      end
      if (done && (seq == ICW1 || seq == ICW2 || seq == ICW3 || seq == ICW4) && nseq == SEQ_IDLE)
        init_done <= 1'b1;
    end
  // read data captured on the last strobe clock, valid on the first HOLD clock
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= smp && seq == ACC;
      if (smp && seq == ACC) rsp_rdata <= din;
    end
`ifdef PIC_INTA_EN
  assign irq = intr;
  assign inta_n = ia_n;
  // interrupt vector captured at the end of the second INTA pulse
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      vec_valid <= 1'b0;
      vec <= '0;
    end else begin
      vec_valid <= smp && seq == INTA2;
      if (smp && seq == INTA2) vec <= din;
    end
`else
  logic unused_ia;
  assign irq = 1'b0;
  assign unused_ia = ia_n;
`endif
endmodule

// File: tb/tb_pic_host_bus_master.sv
// tb_pic_host_bus_master: directed vector bench for the PIC host bus master
`timescale 1ns/1ps
module tb_pic_host_bus_master;
  logic clk = 0, rstn = 0, init_go = 0, req_valid = 0, req_rd = 0, req_a0 = 0, force_drv = 0;
  logic [7:0] icw1 = 0, icw2 = 0, icw3 = 0, icw4 = 0, req_wdata = 0, mval = 0, dv;
  logic init_done, err_icw1, req_ready, rsp_valid, CSn, wrn, rdn, A0;
  logic [7:0] rsp_rdata;
  tri [0:7] D;
  int checks = 0, errors = 0;
`ifdef PIC_INTA_EN
  logic intr = 0, inta_n, vec_valid;
  logic [7:0] vec;
  wire mdrv = !rdn || !inta_n || force_drv;
`else
  wire mdrv = !rdn || force_drv;
`endif
  pic_host_bus_master dut (
    .clk(clk), .rstn(rstn), .init_go(init_go), .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
    .init_done(init_done), .err_icw1(err_icw1), .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_a0(req_a0), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .CSn(CSn), .wrn(wrn), .rdn(rdn), .A0(A0), .D(D)
`ifdef PIC_INTA_EN
    , .intr(intr), .inta_n(inta_n), .vec_valid(vec_valid), .vec(vec)
`endif
  );
  always #5 clk = ~clk;
  for (genvar i = 0; i < 8; i++) begin : g_m
    assign D[i] = mdrv ? mval[i] : 1'bz;
  end
  always_comb for (int i = 0; i < 8; i++) dv[i] = D[i];

  typedef struct {logic a0; logic [7:0] d; int wl; int rl; int cl; int gap;} cyc_t;
  cyc_t q[$];
  int cs_len = 0, wl = 0, rl = 0, gap = 0, cgap = 0, both = 0, rv_cnt = 0, ia_cnt = 0, vv_cnt = 0;
  logic ca0 = 0, pia = 1;
  logic [7:0] cd = 0;
  always @(negedge clk) begin
    if (!rstn) begin
      cs_len = 0; wl = 0; rl = 0; gap = 0;
    end else begin
      if (!wrn && !rdn) both++;
      if (rsp_valid) rv_cnt++;
      if (!CSn) begin
        if (cs_len == 0) cgap = gap;
        cs_len++;
        gap = 0;
        if (!wrn || !rdn) begin ca0 = A0; cd = dv; end
        if (!wrn) wl++;
        if (!rdn) rl++;
      end else begin
        if (cs_len != 0) q.push_back('{ca0, cd, wl, rl, cs_len, cgap});
        cs_len = 0; wl = 0; rl = 0;
        gap++;
      end
`ifdef PIC_INTA_EN
      if (!inta_n && pia) ia_cnt++;
      pia = inta_n;
      if (vec_valid) vv_cnt++;
`endif
    end
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s got %b expected %b", nm, act, exp); end
  endtask
  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s got %h expected %h", nm, act, exp); end
  endtask
  task automatic chkn(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin errors++; $display("FAIL %s got %0d expected %0d", nm, act, exp); end
  endtask

  typedef struct {logic [7:0] i1, i2, i3, i4; int n; logic [3:0][8:0] w; logic done, err;} vec_t;
  vec_t t[5];

  task automatic do_init(input logic [7:0] a, b, c, d);
    icw1 = a; icw2 = b; icw3 = c; icw4 = d; init_go = 1;
    @(negedge clk);
    init_go = 0; icw1 = 8'hEE; icw2 = 8'hEE; icw3 = 8'hEE; icw4 = 8'hEE;
  endtask

  initial begin
    int r0, i0, v0;
    t[0] = '{8'h13, 8'h20, 8'h55, 8'h01, 3, {9'h000, 9'h101, 9'h120, 9'h013}, 1'b1, 1'b0};
    t[1] = '{8'h03, 8'h20, 8'h55, 8'h01, 0, {9'h000, 9'h000, 9'h000, 9'h000}, 1'b0, 1'b1};
    t[2] = '{8'h11, 8'h28, 8'h04, 8'h03, 4, {9'h103, 9'h104, 9'h128, 9'h011}, 1'b1, 1'b0};
    t[3] = '{8'h12, 8'h40, 8'h77, 8'h88, 2, {9'h000, 9'h000, 9'h140, 9'h012}, 1'b1, 1'b0};
    t[4] = '{8'h10, 8'h30, 8'h02, 8'h99, 3, {9'h000, 9'h102, 9'h130, 9'h010}, 1'b1, 1'b0};
    repeat (3) @(negedge clk);
    rstn = 1;
    @(negedge clk);
    chk1("rst CSn", CSn, 1); chk1("rst wrn", wrn, 1); chk1("rst rdn", rdn, 1); chk1("rst A0", A0, 0);
    chk1("rst init_done", init_done, 0); chk1("rst err_icw1", err_icw1, 0);
    chk1("rst req_ready", req_ready, 0); chk1("rst rsp_valid", rsp_valid, 0);
    chk8("rst rsp_rdata", rsp_rdata, 8'h00);
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      q.delete();
      do_init(t[v].i1, t[v].i2, t[v].i3, t[v].i4);
      for (int k = 0; k < 150 && !init_done; k++) @(negedge clk);
      repeat (4) @(negedge clk);
      chk1($sformatf("v%0d init_done", v), init_done, t[v].done);
      chk1($sformatf("v%0d err_icw1", v), err_icw1, t[v].err);
      chk1($sformatf("v%0d req_ready", v), req_ready, t[v].done);
      chkn($sformatf("v%0d writes", v), q.size(), t[v].n);
      for (int k = 0; k < t[v].n && k < q.size(); k++) begin
        chk1($sformatf("v%0d w%0d A0", v, k), q[k].a0, t[v].w[k][8]);
        chk8($sformatf("v%0d w%0d data", v, k), q[k].d, t[v].w[k][7:0]);
        chkn($sformatf("v%0d w%0d wrn_low", v, k), q[k].wl, 2);
        chkn($sformatf("v%0d w%0d csn_low", v, k), q[k].cl, 4);
        if (k > 0) chkn($sformatf("v%0d w%0d gap", v, k), q[k].gap, 2);
      end
    end
    q.delete();
    r0 = rv_cnt;
    req_rd = 0; req_a0 = 0; req_wdata = 8'h0B; req_valid = 1;
    for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
    chk1("ocw ready", req_ready, 1);
    @(negedge clk);
    req_valid = 0;
    for (int k = 0; k < 50 && q.size() < 1; k++) @(negedge clk);
    chkn("ocw cycles", q.size(), 1);
    if (q.size() > 0) begin
      chk1("ocw A0", q[0].a0, 0); chk8("ocw data", q[0].d, 8'h0B); chkn("ocw wrn_low", q[0].wl, 2);
    end
    mval = 8'h5A; req_rd = 1; req_a0 = 0; req_wdata = 8'hA5; req_valid = 1;
    for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
    chk1("rd ready", req_ready, 1);
    @(negedge clk);
    req_valid = 0;
    for (int k = 0; k < 50 && !rsp_valid; k++) @(negedge clk);
    chk1("rd rsp_valid", rsp_valid, 1);
    chk8("rd rsp_rdata", rsp_rdata, 8'h5A);
    repeat (8) @(negedge clk);
    chkn("rd rsp_valid pulses", rv_cnt - r0, 1);
    chk8("rd rsp_rdata held", rsp_rdata, 8'h5A);
    chkn("rd cycles", q.size(), 2);
    if (q.size() > 1) begin
      chk8("rd bus D", q[1].d, 8'h5A); chkn("rd rdn_low", q[1].rl, 2); chkn("rd wrn_low", q[1].wl, 0);
    end
    do_init(8'h13, 8'h20, 8'h00, 8'h01);
    for (int k = 0; k < 50 && !(!wrn && A0); k++) @(negedge clk);
    chk1("rst5 icw2 strobe", !wrn && A0, 1);
    chk8("rst5 icw2 data", dv, 8'h20);
    #2;
    mval = 8'hDF; force_drv = 1; rstn = 0;
    #1;
    chk1("rst5 CSn", CSn, 1); chk1("rst5 wrn", wrn, 1); chk1("rst5 rdn", rdn, 1);
    chk8("rst5 D released", dv, 8'hDF);
    repeat (2) @(negedge clk);
    rstn = 1; force_drv = 0;
    q.delete();
    repeat (10) @(negedge clk);
    chk1("rst5 init_done", init_done, 0); chk1("rst5 req_ready", req_ready, 0);
    chk1("rst5 CSn idle", CSn, 1); chkn("rst5 bus idle", q.size(), 0);
`ifdef PIC_INTA_EN
    do_init(8'h13, 8'h20, 8'h00, 8'h01);
    for (int k = 0; k < 150 && !init_done; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    q.delete();
    i0 = ia_cnt; v0 = vv_cnt; mval = 8'h48; intr = 1;
    for (int k = 0; k < 100 && !vec_valid; k++) @(negedge clk);
    intr = 0;
    chk1("inta vec_valid", vec_valid, 1);
    repeat (10) @(negedge clk);
    chkn("inta pulses", ia_cnt - i0, 2);
    chkn("inta vec_valid pulses", vv_cnt - v0, 1);
    chk8("inta vec", vec, 8'h48);
    chkn("inta CSn low cycles", q.size(), 0);
`else
    i0 = 0; v0 = 0;
`endif
    chkn("wrn rdn overlap", both, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
